// File: rtl/icache_assoc_fill_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the default geometry, the address-field widths derived from it, the
// field typedefs and the miss/fill controller state encoding.
package icache_assoc_pkg;

   localparam int IC_ADDR_WIDTH  = 32;
   localparam int IC_DATA_WIDTH  = 32;
   localparam int IC_FETCH_WIDTH = 2;
   localparam int IC_WAY_NUM     = 2;
   localparam int IC_SET_NUM     = 64;
   localparam int IC_LINE_WORDS  = 4;

   // Byte address = {tag, index, word offset, byte-in-word}
   localparam int BYTE_W   = $clog2(IC_DATA_WIDTH / 8);
   localparam int OFFSET_W = $clog2(IC_LINE_WORDS);
   localparam int INDEX_W  = $clog2(IC_SET_NUM);
   localparam int TAG_W    = IC_ADDR_WIDTH - INDEX_W - OFFSET_W - BYTE_W;
   localparam int WAY_W    = (IC_WAY_NUM > 1) ? $clog2(IC_WAY_NUM) : 1;

   typedef logic [TAG_W-1:0]                        IcTag;
   typedef logic [INDEX_W-1:0]                      IcIndex;
   typedef logic [WAY_W-1:0]                        IcWayPtr;
   typedef logic [IC_LINE_WORDS*IC_DATA_WIDTH-1:0]  IcLine;

   typedef enum logic [2:0] {
      FLUSH = 3'd0,
      IDLE  = 3'd1,
      REQ   = 3'd2,
      WAIT  = 3'd3,
      FILL  = 3'd4
   } IcFillState;

endpackage

// File: rtl/icache_assoc_fill_way_array.sv
// One way of the instruction cache: per-set valid bit, tag and data line.
// Reads are synchronous (registered outputs next cycle). A write in the same
// cycle as a read of the same set returns the old contents.
// Ports:
//   clk                      clock
//   rdIndex                  set to read this cycle
//   rdValid/rdTag/rdLine     registered read results
//   wrEn/wrIndex/wrTag/wrLine  line fill: writes tag, data and sets valid
//   clrEn/clrIndex           clears the valid bit of one set (flush)
module icache_way_array #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 22,
   parameter int LINE_W  = 128,
   parameter int SET_NUM = 64
) (
   input  logic               clk,
   input  logic [INDEX_W-1:0] rdIndex,
   output logic               rdValid,
   output logic [TAG_W-1:0]   rdTag,
   output logic [LINE_W-1:0]  rdLine,
   input  logic               wrEn,
   input  logic [INDEX_W-1:0] wrIndex,
   input  logic [TAG_W-1:0]   wrTag,
   input  logic [LINE_W-1:0]  wrLine,
   input  logic               clrEn,
   input  logic [INDEX_W-1:0] clrIndex
);

   logic [SET_NUM-1:0] validBits;
   logic [TAG_W-1:0]   tagMem  [SET_NUM];
   logic [LINE_W-1:0]  dataMem [SET_NUM];

   always_ff @(posedge clk) begin
      rdValid <= validBits[rdIndex];
      rdTag   <= tagMem[rdIndex];
      rdLine  <= dataMem[rdIndex];
      if (wrEn) begin
         tagMem[wrIndex]  <= wrTag;
         dataMem[wrIndex] <= wrLine;
      end
   end

   // Valid bits live in flops so a flush can clear one set per cycle.
   // The controller never fills and flushes in the same cycle.
   always_ff @(posedge clk) begin
      if (clrEn) begin
         validBits[clrIndex] <= 1'b0;
      end else if (wrEn) begin
         validBits[wrIndex] <= 1'b1;
      end
   end

endmodule

// File: rtl/icache_assoc_fill.sv
// N-way set-associative instruction cache with its own miss/fill controller,
// per-set round-robin victim selection and a one-set-per-cycle flush.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_next_addr       address indexing the arrays this cycle (registered)
//   fetch_re              read enable for the address registered last cycle
//   fetch_hit/fetch_data  per-lane hit and instruction word
//   flush_req             invalidate all lines (pulse)
//   busy                  high in every controller state except IDLE
//   mem_req_*             line request to memory
//   mem_resp_*            line fill data from memory
//   dbgState              current controller state
//
// Memory handshake: mem_req_valid rises with mem_req_addr and both stay
// stable until a rising clk edge sees mem_req_valid && mem_req_ready; that
// edge is the transfer. mem_resp_valid is a single-cycle pulse carrying the
// whole line, one per accepted request, with no back-pressure; it is only
// honoured in WAIT.
module icache_assoc_fill import icache_assoc_pkg::*; #(
   parameter int ADDR_WIDTH  = IC_ADDR_WIDTH,
   parameter int DATA_WIDTH  = IC_DATA_WIDTH,
   parameter int FETCH_WIDTH = IC_FETCH_WIDTH,
   parameter int WAY_NUM     = IC_WAY_NUM,
   parameter int SET_NUM     = IC_SET_NUM,
   parameter int LINE_WORDS  = IC_LINE_WORDS
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              fetch_re,
   input  logic [ADDR_WIDTH-1:0]             fetch_next_addr,
   output logic [FETCH_WIDTH-1:0]            fetch_hit,
   output logic [FETCH_WIDTH*DATA_WIDTH-1:0] fetch_data,
   input  logic                              flush_req,
   output logic                              busy,
   output logic                              mem_req_valid,
   input  logic                              mem_req_ready,
   output logic [ADDR_WIDTH-1:0]             mem_req_addr,
   input  logic                              mem_resp_valid,
   input  logic [LINE_WORDS*DATA_WIDTH-1:0]  mem_resp_data,
   output IcFillState                        dbgState
);

   localparam int byteW   = $clog2(DATA_WIDTH / 8);
   localparam int offW    = $clog2(LINE_WORDS);
   localparam int idxW    = $clog2(SET_NUM);
   localparam int lineLsb = byteW + offW;
   localparam int tagLsb  = lineLsb + idxW;
   localparam int tagW    = ADDR_WIDTH - tagLsb;
   localparam int wayW    = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
   localparam int lineW   = LINE_WORDS * DATA_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] lineMask =
      ~((ADDR_WIDTH'(1) << lineLsb) - ADDR_WIDTH'(1));
   localparam logic [idxW-1:0] lastSet = idxW'(SET_NUM - 1);
   localparam logic [wayW-1:0] lastWay = wayW'(WAY_NUM - 1);

   IcFillState       state;
   logic [ADDR_WIDTH-1:0] curAddr;
   logic [idxW-1:0]  flushCnt;
   logic             flushPending;
   logic             postFill;
   logic [lineW-1:0] fillLine;
   logic [wayW-1:0]  victimPtr [SET_NUM];

   logic [offW-1:0]  curOffset;
   logic [tagW-1:0]  curTag;
   logic [idxW-1:0]  nextIndex;
   logic [idxW-1:0]  fillIndex;
   logic [tagW-1:0]  fillTag;
   logic             flushing;

   assign curOffset = curAddr[byteW +: offW];
   assign curTag    = curAddr[tagLsb +: tagW];
   assign nextIndex = fetch_next_addr[lineLsb +: idxW];
   // The request address is held through FILL, so it names the set and tag.
   assign fillIndex = mem_req_addr[lineLsb +: idxW];
   assign fillTag   = mem_req_addr[tagLsb +: tagW];
   assign flushing  = (state == FLUSH);
   assign dbgState  = state;

   always_ff @(posedge clk) begin
      if (rst) curAddr <= '0;
      else     curAddr <= fetch_next_addr;
   end

   logic [WAY_NUM-1:0] wayValid;
   logic [WAY_NUM-1:0] wayHit;
   logic [WAY_NUM-1:0] wayWr;
   logic [tagW-1:0]    wayTag  [WAY_NUM];
   logic [lineW-1:0]   wayLine [WAY_NUM];

   for (genvar w = 0; w < WAY_NUM; w++) begin : gWay
      assign wayHit[w] = wayValid[w] && (wayTag[w] == curTag);
      assign wayWr[w]  = (state == FILL) && (victimPtr[fillIndex] == wayW'(w));

      icache_way_array #(
         .INDEX_W (idxW),
         .TAG_W   (tagW),
         .LINE_W  (lineW),
         .SET_NUM (SET_NUM)
      ) uWay (
         .clk      (clk),
         .rdIndex  (nextIndex),
         .rdValid  (wayValid[w]),
         .rdTag    (wayTag[w]),
         .rdLine   (wayLine[w]),
         .wrEn     (wayWr[w]),
         .wrIndex  (fillIndex),
         .wrTag    (fillTag),
         .wrLine   (fillLine),
         .clrEn    (flushing),
         .clrIndex (flushCnt)
      );
   end

   // At most one way matches, so OR-ing the gated lines selects it.
   logic [lineW-1:0]      hitLine;
   logic [DATA_WIDTH-1:0] hitWords [LINE_WORDS];
   logic                  anyHit;
   logic                  lookupOk;
   logic                  missNow;
   logic [offW:0]         wordIdx;

   always_comb begin
      hitLine = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         if (wayHit[w]) hitLine = hitLine | wayLine[w];
      end
      for (int k = 0; k < LINE_WORDS; k++) begin
         hitWords[k] = hitLine[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign anyHit   = |wayHit;
   // The first IDLE cycle after a fill still sees the pre-fill array contents.
   assign lookupOk = (state == IDLE) && !postFill && fetch_re;
   // Lane 0 is always inside the line, so a lane-0 miss is a line miss.
   assign missNow  = lookupOk && !anyHit;

   always_comb begin
      fetch_hit  = '0;
      fetch_data = '0;
      wordIdx    = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         wordIdx = {1'b0, curOffset} + (offW + 1)'(i);
         if (wordIdx < (offW + 1)'(LINE_WORDS)) begin
            fetch_hit[i] = lookupOk && anyHit;
            fetch_data[i*DATA_WIDTH +: DATA_WIDTH] = hitWords[wordIdx[offW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FLUSH;
         flushCnt      <= '0;
         flushPending  <= 1'b0;
         postFill      <= 1'b0;
         busy          <= 1'b1;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         for (int s = 0; s < SET_NUM; s++) victimPtr[s] <= '0;
      end else begin
         postFill <= 1'b0;
         case (state)
            FLUSH: begin
               flushCnt     <= flushCnt + 1'b1;
               flushPending <= 1'b0;
               if (flushCnt == lastSet) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (missNow) begin
                  state         <= REQ;
                  busy          <= 1'b1;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= curAddr & lineMask;
                  flushPending  <= flush_req;
               end else if (flush_req) begin
                  state    <= FLUSH;
                  busy     <= 1'b1;
                  flushCnt <= '0;
               end
            end
            REQ: begin
               if (flush_req) flushPending <= 1'b1;
               if (mem_req_ready) begin
                  state         <= WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (flush_req) flushPending <= 1'b1;
               if (mem_resp_valid) begin
                  state    <= FILL;
                  fillLine <= mem_resp_data;
               end
            end
            FILL: begin
               victimPtr[fillIndex] <= (victimPtr[fillIndex] == lastWay) ?
                                       '0 : victimPtr[fillIndex] + 1'b1;
               postFill <= 1'b1;
               if (flushPending || flush_req) begin
                  state        <= FLUSH;
                  flushCnt     <= '0;
                  flushPending <= 1'b0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= FLUSH;
               flushCnt <= '0;
               busy     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_assoc_fill.sv
// Directed bench for icache_assoc_fill. Stimulus tasks push the expected
// lookup result / memory request into queues; a negedge monitor pops and
// compares whenever the DUT presents a lookup (fetch_re) or a new request.
module tb_icache_assoc_fill;
   import icache_assoc_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int FW    = 2;
   localparam int LINEW = 4 * DW;
   localparam int EW    = FW + FW * DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              fetch_re = 1'b0;
   logic [AW-1:0]     fetch_next_addr = '0;
   logic [FW-1:0]     fetch_hit;
   logic [FW*DW-1:0]  fetch_data;
   logic              flush_req = 1'b0;
   logic              busy;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic [AW-1:0]     mem_req_addr;
   logic              mem_resp_valid = 1'b0;
   logic [LINEW-1:0]  mem_resp_data = '0;
   IcFillState        dbgState;

   icache_assoc_fill dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_re        (fetch_re),
      .fetch_next_addr (fetch_next_addr),
      .fetch_hit       (fetch_hit),
      .fetch_data      (fetch_data),
      .flush_req       (flush_req),
      .busy            (busy),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .dbgState        (dbgState)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [EW-1:0] expFetch [$];
   logic [AW-1:0] expReq   [$];
   logic          prevReqValid = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [EW-1:0]    e;
      logic [FW*DW-1:0] mask;
      if (fetch_re) begin
         if (expFetch.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_unexpected got_hit=%0b want=no_lookup @%0t", fetch_hit, $time);
         end else begin
            e    = expFetch.pop_front();
            mask = '0;
            for (int i = 0; i < FW; i++) if (e[FW*DW+i]) mask[i*DW +: DW] = '1;
            check("fetch_hit", 64'(fetch_hit), 64'(e[EW-1 -: FW]));
            check("fetch_data", 64'(fetch_data & mask), 64'(e[FW*DW-1:0] & mask));
         end
      end
      if (mem_req_valid && !prevReqValid) begin
         if (expReq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_unexpected got_addr=%0h want=no_request @%0t", mem_req_addr, $time);
         end else begin
            check("req_addr", 64'(mem_req_addr), 64'(expReq.pop_front()));
         end
      end
      prevReqValid = mem_req_valid;
   end

   // ---------------- driver tasks ----------------
   function automatic logic [LINEW-1:0] mkLine(input logic [DW-1:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   // Presents addr for one cycle, then looks it up with fetch_re=1.
   task automatic doFetch(input logic [AW-1:0] a, input logic [FW-1:0] h,
                          input logic [DW-1:0] l0, input logic [DW-1:0] l1, input logic miss);
      fetch_next_addr = a;
      fetch_re = 1'b0;
      @(posedge clk); #1;
      fetch_re = 1'b1;
      expFetch.push_back({h, l1, l0});
      if (miss) expReq.push_back(a & 32'hFFFF_FFF0);
      @(posedge clk); #1;
      fetch_re = 1'b0;
   endtask

   // mode 0: full fill; mode 1: flush_req pulse in WAIT then fill;
   // mode 2: stop once WAIT is reached. Returns #1 into the cycle after.
   task automatic serveMiss(input int dly, input logic [LINEW-1:0] line, input int mode);
      int n = 0;
      while (!mem_req_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mem_req_valid) begin
         total++;
         bad++;
         $display("FAIL req_timeout got_valid=0 want_valid=1 @%0t", $time);
         return;
      end
      repeat (dly) begin
         @(posedge clk); #1;
      end
      check("req_hold", 64'(mem_req_valid), 64'(1));
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      check("req_drop", 64'(mem_req_valid), 64'(0));
      check("busy_wait", 64'(busy), 64'(1));
      if (mode == 2) return;
      if (mode == 1) begin
         flush_req = 1'b1;
         @(posedge clk); #1;
         flush_req = 1'b0;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = line;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
   endtask

   task automatic countBusy(output int n);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
   endtask

   task automatic afterFill();
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   localparam logic [DW-1:0] A = 32'hA000_0001, B = 32'hB000_0002,
                             C = 32'hC000_0003, D = 32'hD000_0004;

   initial begin
      int n;
      int m;
      logic [LINEW-1:0] l1, l2, l3, lf, lf2, lr, ljunk;
      l1    = mkLine(32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
      l2    = mkLine(32'h2222_0000, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003);
      l3    = mkLine(32'h3333_0000, 32'h3333_0001, 32'h3333_0002, 32'h3333_0003);
      lf    = mkLine(32'hF0F0_0000, 32'hF0F0_0001, 32'hF0F0_0002, 32'hF0F0_0003);
      lf2   = mkLine(32'hF1F1_0000, 32'hF1F1_0001, 32'hF1F1_0002, 32'hF1F1_0003);
      lr    = mkLine(32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003);
      ljunk = mkLine(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);

      // Reset: flush of all 64 sets keeps busy high.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", 64'(busy), 64'(1));
      check("reset_req_valid", 64'(mem_req_valid), 64'(0));
      check("reset_hit", 64'(fetch_hit), 64'(0));
      countBusy(n);
      check("reset_flush_len", 64'(n), 64'(64));

      // Cold miss on 0x100, fill A..D, stale cycle, then hits.
      doFetch(32'h100, 2'b00, '0, '0, 1'b1);
      serveMiss(2, mkLine(A, B, C, D), 0);
      fetch_next_addr = 32'h104;
      @(posedge clk); #1;
      fetch_re = 1'b1;
      expFetch.push_back({2'b00, 64'h0});
      @(posedge clk); #1;
      expFetch.push_back({2'b11, C, B});
      @(posedge clk); #1;
      fetch_re = 1'b0;
      doFetch(32'h10C, 2'b01, D, '0, 1'b0);
      doFetch(32'h108, 2'b11, C, D, 1'b0);

      // Set 0: tags 1,2,3 -> tag 3 evicts tag 1 (round-robin).
      doFetch(32'h400, 2'b00, '0, '0, 1'b1);
      serveMiss(0, l1, 0);
      afterFill();
      doFetch(32'h800, 2'b00, '0, '0, 1'b1);
      serveMiss(1, l2, 0);
      afterFill();
      doFetch(32'hC00, 2'b00, '0, '0, 1'b1);
      serveMiss(3, l3, 0);
      afterFill();
      doFetch(32'h800, 2'b11, 32'h2222_0000, 32'h2222_0001, 1'b0);
      doFetch(32'hC04, 2'b11, 32'h3333_0001, 32'h3333_0002, 1'b0);
      doFetch(32'h400, 2'b00, '0, '0, 1'b1);
      serveMiss(0, l1, 0);
      afterFill();
      doFetch(32'h408, 2'b11, 32'h1111_0002, 32'h1111_0003, 1'b0);

      // flush_req during WAIT: fill completes, then a full flush.
      doFetch(32'h200, 2'b00, '0, '0, 1'b1);
      serveMiss(1, lf, 1);
      afterFill();
      countBusy(n);
      check("flush_wait_len", 64'(n), 64'(64));
      doFetch(32'h200, 2'b00, '0, '0, 1'b1);
      serveMiss(0, lf2, 0);
      afterFill();
      doFetch(32'h204, 2'b11, 32'hF1F1_0001, 32'hF1F1_0002, 1'b0);
      doFetch(32'h104, 2'b00, '0, '0, 1'b1);
      serveMiss(0, mkLine(A, B, C, D), 0);
      afterFill();

      // Reset while waiting for the line; the late response is dropped.
      doFetch(32'h300, 2'b00, '0, '0, 1'b1);
      serveMiss(0, ljunk, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_wait_busy", 64'(busy), 64'(1));
      check("rst_wait_req_valid", 64'(mem_req_valid), 64'(0));
      mem_resp_valid = 1'b1;
      mem_resp_data  = ljunk;
      n = 1;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      countBusy(m);
      check("rst_flush_len", 64'(n + m), 64'(64));
      doFetch(32'h300, 2'b00, '0, '0, 1'b1);
      serveMiss(2, lr, 0);
      afterFill();
      doFetch(32'h308, 2'b11, 32'h5A5A_0002, 32'h5A5A_0003, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("fetch_q_empty", 64'(expFetch.size()), 64'(0));
      check("req_q_empty", 64'(expReq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_assoc_fill.md
Name: icache_assoc_fill

Overview:
- Parametrised N-way set-associative instruction cache with an integrated miss/fill controller and a flush sequencer.
- Successor to the fixed-geometry ICache, which relies on an external filler. It sits between the fetch stage and the memory system.
- Each cycle it serves FETCH_WIDTH consecutive instruction words from one line.
- It issues line requests itself and selects victims with a per-set round-robin pointer.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, instruction word width.
- FETCH_WIDTH, 2, words returned per cycle.
- WAY_NUM, 2, associativity (power of 2, ≥1).
- SET_NUM, 64, sets (power of 2).
- LINE_WORDS, 4, words per line (power of 2, ≥FETCH_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_re  in  1  read enable for the address registered last cycle
- fetch_next_addr  in  ADDR_WIDTH  address used to index the arrays this cycle; registered internally as the current fetch address
- fetch_hit  out  FETCH_WIDTH  per-lane hit
- fetch_data  out  FETCH_WIDTH*DATA_WIDTH  per-lane instruction
- flush_req  in  1  invalidate all lines (pulse)
- busy  out  1  miss or flush in progress
- mem_req_valid  out  1  line request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  line-aligned miss address
- mem_resp_valid  in  1  line data valid (exactly one pulse per request)
- mem_resp_data  in  LINE_WORDS*DATA_WIDTH  fill line

Behaviour:
- Address split: word offset log2(LINE_WORDS), index log2(SET_NUM), tag = remaining bits. The low log2(DATA_WIDTH/8) bits are ignored.
- Arrays: tag+valid and data arrays read synchronously with fetch_next_addr. The current address register loads fetch_next_addr every cycle; rst clears it to 0.
- Lookup happens in cycle t+1 for an address presented in cycle t.
  - A lane i hits when the lane is within the line (offset+i < LINE_WORDS), some way is valid with a matching tag, state==IDLE, not first-cycle-after-fill, and fetch_re=1.
  - Lanes crossing the line end report hit=0.
  - A hit in multiple ways cannot occur; behaviour in that case is undefined.
- Outputs: fetch_hit is 0 when not hitting. fetch_data is don't-care when hit=0.
- FSM states: FLUSH, IDLE, REQ, WAIT, FILL.
- Reset enters FLUSH with the set counter at 0. busy=1, mem_req_valid=0, fetch_hit=0, all victim pointers=0.
- FLUSH: clears valid in all ways of one set per cycle. After set SET_NUM-1 it goes to IDLE, so flush takes SET_NUM cycles.
- IDLE:
  - fetch_re=1 with lane 0 missing → REQ. The line-aligned current address is latched into mem_req_addr.
  - flush_req=1 (with no miss) → FLUSH.
  - Miss and flush_req in the same cycle: the miss wins and the flush is recorded as pending.
- REQ: mem_req_valid=1 with the address held stable. On mem_req_ready → WAIT.
- WAIT: on mem_resp_valid → FILL. mem_resp_valid seen in REQ is illegal.
- FILL (one cycle):
  - Writes the line, tag and valid=1 into the way at victim_ptr[set].
  - Increments victim_ptr[set] modulo WAY_NUM.
  - Goes to FLUSH if a flush is pending, otherwise to IDLE.
- busy=1 in every state except IDLE.
- Post-fill stale cycle: the arrays read old data on read-during-write. The first IDLE cycle after FILL forces fetch_hit=0 and does not start a new miss. The refetch hits from the next cycle.
- flush_req arriving in REQ, WAIT or FILL is recorded as pending. flush_req arriving in FLUSH is ignored.
- rst mid-miss: the outstanding request is abandoned, the FSM goes to FLUSH, and a late mem_resp_valid is ignored.

Decomposition:
- Package icache_assoc_pkg holds:
  - derived widths: OFFSET_W, INDEX_W, TAG_W, WAY_W;
  - typedefs: IcTag, IcIndex, IcWayPtr, IcLine;
  - enum IcFillState.
- One natural sub-module: icache_way_array, a single way's synchronous tag/valid/data RAM instantiated WAY_NUM times.
- The FSM and replacement logic stay in the top.

Test Plan:
- Reset → busy=1 for 64 cycles, then 0; fetch of 0x100 → fetch_hit=00, mem_req_addr=0x100.
- Miss at 0x104: ready after 2 cycles, response with words A,B,C,D.
  - One stale cycle with hit=00.
  - Then hit=11 with data {B,C} (lane0=B, lane1=C).
- Fetch at 0x10C (last word of line) → hit=01 with lane 0 = D; lane 1 reports 0.
- Fill set 0 with tags T1, T2, T3 (WAY_NUM=2):
  - T3 evicts T1 (the round-robin victim).
  - Refetching T1 misses; refetching T2 hits.
- flush_req during WAIT → fill completes, FLUSH runs for 64 cycles, then the previously filled line misses.
- rst asserted in WAIT followed by a late mem_resp_valid → no array write; after the reset flush, the address misses and a new request is issued.
